// File: rtl/hs_npu_pkg.sv
// HS-NPU shared types: phase encoding and per-phase beat counts.
// Used by the load sequencer and the systolic array control.
package hs_npu_pkg;

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    LOADING_WEIGHTS  = 3'd1,
    LOADING_INPUTS   = 3'd2,
    LOADING_BIAS     = 3'd3,
    LOADING_SUMS     = 3'd4,
    READY_TO_COMPUTE = 3'd5,
    COMPUTING        = 3'd6,
    SAVING           = 3'd7
  } loading_state_t;

  // Non-streaming phases report one beat so the terminal index stays 0.
  function automatic int unsigned phase_beats(
    loading_state_t s,
    int unsigned    rows,
    int unsigned    cols,
    int unsigned    b
  );
    int unsigned n;
    n = 1;
    case (s)
      LOADING_WEIGHTS: n = rows * cols;
      LOADING_INPUTS:  n = b * rows;
      LOADING_BIAS:    n = cols;
      LOADING_SUMS:    n = b * cols;
      SAVING:          n = b * cols;
      default:         n = 1;
    endcase
    return n;
  endfunction

  function automatic logic is_loading(loading_state_t s);
    return (s == LOADING_WEIGHTS) || (s == LOADING_INPUTS) ||
           (s == LOADING_BIAS)    || (s == LOADING_SUMS);
  endfunction

endpackage

// File: rtl/hs_npu_beat_counter.sv
// Beat counter: clear beats load beats increment.
// last flags the terminal count of the current phase.
module hs_npu_beat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == term);

endmodule

// File: rtl/hs_npu_load_seq.sv
// HS-NPU load/compute/save sequencer: steers operand beats
// into array buffers, kicks compute and drains results.
module hs_npu_load_seq
  import hs_npu_pkg::*;
#(
  parameter  int ROWS      = 8,
  parameter  int COLS      = 8,
  parameter  int MAX_BATCH = 16,
  localparam int CAP       = ROWS * COLS * MAX_BATCH,
  localparam int IDX_W     = (CAP > 1) ? $clog2(CAP) : 1,
  localparam int BW        = $clog2(MAX_BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [BW-1:0]    cfg_batch,
  input  logic             cfg_reuse_w,
  input  logic             cfg_use_sums,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             ld_wen,
  output logic [2:0]       ld_sel,
  output logic [IDX_W-1:0] ld_idx,
  output logic [31:0]      ld_data,
  output logic             cmp_start,
  input  logic             cmp_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [2:0]       state,
  output logic             w_loaded,
  output logic             done,
  output logic             err
);

  loading_state_t   st;
  loading_state_t   nxt;
  logic [BW-1:0]    b_q;
  logic             sums_q;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] term;
  logic             last;
  logic             in_fire;
  logic             out_fire;
  logic             bad;
  logic             start_ok;
  logic             clr;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign bad      = (cfg_batch == '0) ||
                    (cfg_batch > BW'(MAX_BATCH));
  assign start_ok = (st == IDLE) && start && !bad && !abort;
  assign term     = IDX_W'(phase_beats(st, ROWS, COLS,
                                       32'(b_q)) - 1);
  assign clr      = (nxt != st);
  assign state    = st;

  hs_npu_beat_counter #(
    .W (IDX_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_fire || out_fire),
    .term     (term),
    .cnt      (cnt),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt = st;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (start && !bad) begin
            nxt = (cfg_reuse_w && w_loaded) ?
                  LOADING_INPUTS : LOADING_WEIGHTS;
          end
        end
        LOADING_WEIGHTS: begin
          if (in_fire && last) nxt = LOADING_INPUTS;
        end
        LOADING_INPUTS: begin
          if (in_fire && last) nxt = LOADING_BIAS;
        end
        LOADING_BIAS: begin
          if (in_fire && last) begin
            nxt = sums_q ? LOADING_SUMS : READY_TO_COMPUTE;
          end
        end
        LOADING_SUMS: begin
          if (in_fire && last) nxt = READY_TO_COMPUTE;
        end
        READY_TO_COMPUTE: nxt = COMPUTING;
        COMPUTING: begin
          if (cmp_done) nxt = SAVING;
        end
        SAVING: begin
          if (out_fire && last) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = is_loading(st);
    out_valid = (st == SAVING);
    cmp_start = (st == READY_TO_COMPUTE);
    out_idx   = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      sums_q <= 1'b0;
    end else if (start_ok) begin
      b_q    <= cfg_batch;
      sums_q <= cfg_use_sums;
    end
  end

  // Aborting mid-weights leaves the buffer partially overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_loaded <= 1'b0;
    end else if (abort && st == LOADING_WEIGHTS) begin
      w_loaded <= 1'b0;
    end else if (st == LOADING_WEIGHTS && in_fire && last) begin
      w_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_wen  <= 1'b0;
      ld_sel  <= 3'd0;
      ld_idx  <= '0;
      ld_data <= '0;
    end else begin
      ld_wen <= in_fire;
      if (in_fire) begin
        ld_sel  <= st;
        ld_idx  <= cnt;
        ld_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      err  <= (st == IDLE) && start && bad && !abort;
      done <= (st == SAVING) && out_fire && last && !abort;
    end
  end

endmodule

// File: tb/tb_hs_npu_load_seq.sv
// Self-checking bench for hs_npu_load_seq (2x2 array, batch 4).
// Directed jobs, a start-rejection table and random jobs vs a phase model.
module tb_hs_npu_load_seq;
  import hs_npu_pkg::*;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int MAX_BATCH = 4;
  localparam int IDX_W = 4;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst, start, abort, cfg_reuse_w, cfg_use_sums;
  logic in_valid, cmp_done, out_ready;
  logic [BW-1:0] cfg_batch;
  logic [31:0] in_data;
  logic in_ready, ld_wen, cmp_start, out_valid, w_loaded, done, err;
  logic [2:0] ld_sel, state;
  logic [IDX_W-1:0] ld_idx, out_idx;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  hs_npu_load_seq #(
    .ROWS(ROWS), .COLS(COLS), .MAX_BATCH(MAX_BATCH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_batch(cfg_batch), .cfg_reuse_w(cfg_reuse_w),
    .cfg_use_sums(cfg_use_sums), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ld_wen(ld_wen),
    .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
    .cmp_start(cmp_start), .cmp_done(cmp_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .state(state), .w_loaded(w_loaded),
    .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({in_ready, ld_wen, ld_sel, ld_idx, ld_data, cmp_start,
                out_valid, out_idx, state, w_loaded, done, err});
  endfunction

  typedef struct {
    logic [2:0]       sel;
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } wr_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] data;
  } acc_t;

  wr_t  got_q[$];
  acc_t acc_q[$];

  always @(negedge clk) begin
    if (ld_wen) got_q.push_back('{ld_sel, ld_idx, ld_data});
  end

  // Reference model: phase list and beat counts from the job config.
  bit wl_m;
  loading_state_t exp_ph[$];
  int exp_n[$];
  int n_load;
  int tot_load;

  function automatic void model_job(int b, bit reuse, bit sums);
    exp_ph.delete();
    exp_n.delete();
    if (!(reuse && wl_m)) begin
      exp_ph.push_back(LOADING_WEIGHTS); exp_n.push_back(ROWS * COLS);
    end
    exp_ph.push_back(LOADING_INPUTS); exp_n.push_back(b * ROWS);
    exp_ph.push_back(LOADING_BIAS);   exp_n.push_back(COLS);
    if (sums) begin
      exp_ph.push_back(LOADING_SUMS); exp_n.push_back(b * COLS);
    end
    n_load = exp_ph.size();
    tot_load = 0;
    foreach (exp_n[i]) tot_load += exp_n[i];
    exp_ph.push_back(READY_TO_COMPUTE); exp_n.push_back(0);
    exp_ph.push_back(COMPUTING);        exp_n.push_back(0);
    exp_ph.push_back(SAVING);           exp_n.push_back(b * COLS);
  endfunction

  task automatic idle_inputs();
    start = 0; abort = 0; in_valid = 0; in_data = 0;
    cmp_done = 0; out_ready = 0;
  endtask

  // vmode: 0 full, 1 toggle, 2 random; rmode: 0 full, 2 random
  task automatic run_job(int b, bit reuse, bit sums, int vmode,
                         int rmode, int delay, bit rst_in_save);
    int cyc, comp, res, starts, ph_i, base, n;
    bit fin;
    loading_state_t s;
    loading_state_t seen[$];
    model_job(b, reuse, sums);
    got_q.delete();
    acc_q.delete();
    cyc = 0; comp = 0; res = 0; starts = 0; fin = 0;
    @(posedge clk); #1;
    start = 1; cfg_batch = BW'(b);
    cfg_reuse_w = reuse; cfg_use_sums = sums;
    while (cyc < 500) begin
      @(posedge clk); #1;
      start = 0; in_valid = 0; out_ready = 0; cmp_done = 0;
      s = loading_state_t'(state);
      if (s == IDLE) begin
        fin = 1;
        break;
      end
      cyc++;
      if (seen.size() == 0 || seen[$] != s) seen.push_back(s);
      if (rst_in_save && s == SAVING) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_in_saving_outputs", outs(), 64'd0);
        wl_m = 0;
        return;
      end
      if (cmp_start) starts++;
      if (s == COMPUTING) begin
        comp++;
        cmp_done = (comp >= delay);
      end
      case (vmode)
        0: in_valid = 1;
        1: in_valid = cyc[0];
        default: in_valid = ($urandom_range(0, 99) < 65);
      endcase
      in_data = $urandom;
      if (in_valid && in_ready) acc_q.push_back('{state, in_data});
      out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 65);
      if (out_valid && out_ready) begin
        check("out_idx", 64'(out_idx), 64'(res));
        res++;
      end
    end
    if (!fin) begin
      check("job_timeout_state", 64'(state), 64'(IDLE));
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      return;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("phase_count", 64'(seen.size()), 64'(exp_ph.size()));
    foreach (seen[i]) begin
      if (i < exp_ph.size())
        check("phase_order", 64'(seen[i]), 64'(exp_ph[i]));
    end
    check("result_beats", 64'(res), 64'(b * COLS));
    check("cmp_start_pulses", 64'(starts), 64'd1);
    check("w_loaded_after_job", 64'(w_loaded), 64'd1);
    check("write_count", 64'(got_q.size()), 64'(tot_load));
    check("accept_count", 64'(acc_q.size()), 64'(tot_load));
    ph_i = 0; base = 0;
    n = (got_q.size() < acc_q.size()) ? got_q.size() : acc_q.size();
    for (int k = 0; k < n; k++) begin
      while (ph_i < n_load && k >= base + exp_n[ph_i]) begin
        base += exp_n[ph_i];
        ph_i++;
      end
      if (ph_i < n_load) begin
        check("wr_sel", 64'(got_q[k].sel), 64'(exp_ph[ph_i]));
        check("wr_idx", 64'(got_q[k].idx), 64'(k - base));
        check("wr_data", 64'(got_q[k].data), 64'(acc_q[k].data));
        check("acc_phase", 64'(acc_q[k].st), 64'(exp_ph[ph_i]));
      end
    end
    if (vmode == 0 && rmode == 0) begin
      check("job_cycles", 64'(cyc + 1),
            64'(1 + tot_load + 1 + ((delay > 1) ? delay : 1) + b * COLS));
    end
    wl_m = 1;
    @(posedge clk); #1;
    check("done_single_cycle", 64'(done), 64'd0);
    check("in_ready_idle", 64'(in_ready), 64'd0);
  endtask

  typedef struct {
    int       b;
    bit       reuse;
    bit       exp_err;
    logic [2:0] exp_st;
    bit       exp_wl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 0, 1, IDLE,            1};
    tbl[1] = '{5, 0, 1, IDLE,            1};
    tbl[2] = '{7, 1, 1, IDLE,            1};
    tbl[3] = '{4, 1, 0, LOADING_INPUTS,  1};
    tbl[4] = '{1, 1, 0, LOADING_INPUTS,  1};
    tbl[5] = '{2, 0, 0, LOADING_WEIGHTS, 0};
    tbl[6] = '{3, 1, 0, LOADING_WEIGHTS, 0};
    tbl[7] = '{1, 0, 0, LOADING_WEIGHTS, 0};

    wl_m = 0;
    idle_inputs();
    cfg_batch = 0; cfg_reuse_w = 0; cfg_use_sums = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("reset_outputs", outs(), 64'd0);

    // basic job, then weight reuse, then sums with toggling valid
    run_job(3, 0, 0, 0, 0, 5, 0);
    run_job(1, 1, 0, 0, 0, 0, 0);
    run_job(2, 0, 1, 1, 0, 2, 0);

    // start-rejection and phase-entry table
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = 1; cfg_batch = BW'(tbl[i].b);
      cfg_reuse_w = tbl[i].reuse; cfg_use_sums = 0;
      @(posedge clk); #1;
      start = 0;
      check("tbl_err", 64'(err), 64'(tbl[i].exp_err));
      check("tbl_state", 64'(state), 64'(tbl[i].exp_st));
      check("tbl_in_ready", 64'(in_ready),
            64'(tbl[i].exp_st != IDLE));
      @(posedge clk); #1;
      check("tbl_err_clear", 64'(err), 64'd0);
      if (state != IDLE) abort = 1;
      @(posedge clk); #1;
      abort = 0;
      check("tbl_back_idle", 64'(state), 64'(IDLE));
      check("tbl_w_loaded", 64'(w_loaded), 64'(tbl[i].exp_wl));
    end
    wl_m = 0;

    // reload weights, then abort after 2 weight beats
    run_job(1, 0, 0, 0, 0, 0, 0);
    got_q.delete();
    @(posedge clk); #1;
    start = 1; cfg_batch = 2; cfg_reuse_w = 0; cfg_use_sums = 0;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_data = 32'hA0;
    @(posedge clk); #1;
    in_data = 32'hA1;
    @(posedge clk); #1;
    in_valid = 0; abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_state", 64'(state), 64'(IDLE));
    check("abort_w_loaded", 64'(w_loaded), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("abort_writes", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("abort_wr1_idx", 64'(got_q[1].idx), 64'd1);
      check("abort_wr1_data", 64'(got_q[1].data), 64'hA1);
    end
    wl_m = 0;
    run_job(2, 1, 0, 0, 0, 0, 0);

    // random jobs
    for (int j = 0; j < 20; j++) begin
      int vm;
      vm = $urandom_range(0, 2);
      run_job($urandom_range(1, 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), vm, (vm == 0) ? 0 : 2,
              $urandom_range(0, 6), 0);
    end

    // reset while stalled in SAVING
    run_job(3, 1, 0, 0, 2, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_npu_load_seq.md
# hs_npu_load_seq

Parametrised load/compute/save sequencer for the HS-NPU systolic array. It walks the shared `loading_state_t` phases and counts operand beats from one 32-bit input stream. Each beat is steered to the weight, input, bias or partial-sum buffer with an element index. The block then handshakes compute with the array and drains results. Compared with the fixed single-shot flow, it adds:
- array dimensions and batch depth set by parameters;
- weight reuse across jobs;
- optional partial-sum preload;
- abort and configuration-error handling.

## Interface
Parameters:
- ROWS, 8, array rows (≥1)
- COLS, 8, array columns (≥1)
- MAX_BATCH, 16, maximum input vectors per job (≥1)
- IDX_W, $clog2(ROWS*COLS*MAX_BATCH), localparam, element index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  return to IDLE next cycle, from any state
- cfg_batch  in  $clog2(MAX_BATCH+1)  input vectors in the job; latched on start
- cfg_reuse_w  in  1  skip LOADING_WEIGHTS if weights are already resident; latched on start
- cfg_use_sums  in  1  perform LOADING_SUMS; latched on start
- in_valid  in  1  operand beat valid
- in_data  in  32  operand beat (word)
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- ld_wen  out  1  buffer write strobe
- ld_sel  out  3  target buffer, as a loading_state_t value
- ld_idx  out  IDX_W  element index within the current phase
- ld_data  out  32  registered copy of in_data
- cmp_start  out  1  one-cycle pulse starting the array
- cmp_done  in  1  array finished; honoured only in COMPUTING
- out_valid  out  1  result beat requested
- out_ready  in  1  result sink accepted the beat
- out_idx  out  IDX_W  result element index
- state  out  3  current loading_state_t
- w_loaded  out  1  weights resident
- done  out  1  one-cycle pulse when SAVING completes
- err  out  1  one-cycle pulse on rejected start

## Operation
Beat counts per phase (B = latched cfg_batch):
- LOADING_WEIGHTS: ROWS*COLS
- LOADING_INPUTS: B*ROWS
- LOADING_BIAS: COLS
- LOADING_SUMS: B*COLS
- SAVING: B*COLS

State transitions:
- IDLE with start:
  - cfg_batch==0 or cfg_batch>MAX_BATCH: pulse err, stay in IDLE.
  - Otherwise: go to LOADING_WEIGHTS, or to LOADING_INPUTS when cfg_reuse_w && w_loaded.
- LOADING_WEIGHTS → LOADING_INPUTS after the last weight beat; set w_loaded at the same time.
- LOADING_INPUTS → LOADING_BIAS after the last input beat.
- LOADING_BIAS → LOADING_SUMS after the last bias beat if cfg_use_sums, else → READY_TO_COMPUTE.
- LOADING_SUMS → READY_TO_COMPUTE after the last sum beat.
- READY_TO_COMPUTE: lasts exactly 1 cycle, then → COMPUTING, with cmp_start high in that same cycle.
- COMPUTING → SAVING on cmp_done.
- SAVING → IDLE on the last accepted result beat, with done pulsing in the same cycle.

Counters and stream rules:
- The phase counter clears on every phase entry and increments on each accepted beat.
- ld_idx/out_idx equal the counter value of the beat being transferred.
- in_ready = 1 only in the LOADING_* states. It is a function of the registered state only, so no beat is ever accepted beyond a phase's count.
- out_valid = 1 only in SAVING.

Abort:
- Next state is IDLE and the counter clears.
- If the abort occurs in LOADING_WEIGHTS, clear w_loaded (the buffer is partially overwritten). In any other state, w_loaded is kept.
- A beat presented in the abort cycle is still accepted and written.

Precedence:
- rst beats abort; abort beats every other transition.
- A start asserted outside IDLE is ignored, with no err.

## Timing
- Reset values: state=IDLE, counter=0, w_loaded=0, latched cfg=0. Outputs: in_ready=0, ld_wen=0, ld_sel=0, ld_idx=0, ld_data=0, cmp_start=0, out_valid=0, out_idx=0, done=0, err=0.
- ld_wen/ld_sel/ld_idx/ld_data are registered: ld_wen is high exactly 1 cycle after each accepted beat, and ld_sel holds the phase the beat was accepted in.
- Phase change takes effect the cycle after the last accepted beat. With continuous valid, a phase of N beats occupies exactly N cycles.
- Start-to-first-in_ready latency is 1 cycle.
- err and done are single-cycle registered pulses.
- Minimum job length, from start with cmp_done asserted immediately and every stream at full throughput: 1 + loads + 1 + 1 + B*COLS cycles.

## Structure
- hs_npu_pkg gains:
  - the existing loading_state_t, reused as the state encoding;
  - a localparam function giving the beat count per phase.
- No typedefs are local to the block.
- One sub-module, hs_npu_beat_counter: a loadable counter with clear, increment enable and a terminal-count compare that outputs `last`.

## Test plan
All scenarios use ROWS=COLS=2, MAX_BATCH=4.
- Basic job, B=3, no reuse, no sums:
  - Stimulus: 4 weight, 6 input, 2 bias beats; cmp_done 5 cycles after cmp_start; out_ready tied 1.
  - Required: ld_idx sequences are 0..3, 0..5 and 0..1; 6 result beats; done pulse; w_loaded=1.
- Second job, B=1, cfg_reuse_w=1:
  - Required: state goes IDLE→LOADING_INPUTS; exactly 2+2 load beats; ld_sel never equals LOADING_WEIGHTS.
- cfg_use_sums=1, B=2, with in_valid toggling every other cycle:
  - Required: 4 LOADING_SUMS beats at ld_idx 0..3; no beat lost or duplicated.
- start with cfg_batch=0, and separately cfg_batch=5:
  - Required: err pulses for 1 cycle; state stays IDLE; in_ready stays 0.
- abort after 2 weight beats:
  - Required: IDLE next cycle; w_loaded=0. A following start with cfg_reuse_w=1 still loads 4 weights.
- rst asserted during SAVING with out_ready held 0:
  - Required: every output returns to its reset value on the next edge.
